rr_arb_mux: RTL and testbench

- Registered P_WIDTH-to-1 multiplexer of P_DEPTH-bit channels with valid/ready handshakes.
- Round-robin (or fixed-priority) arbitration selects the channel; the grant is held for multi-beat bursts until the last beat.
- Sits between multiple requesters (e.g. memory/IO bus masters) and one shared sink.
- One output register stage: 1-cycle latency, full throughput.

---
 rtl/rr_arb_mux_pkg.sv | 44 ++++
 rtl/rr_arb_mux_mux.sv | 13 +
 rtl/rr_arb_mux.sv | 112 +++++++++++
 tb/tb_rr_arb_mux.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared types, mode constants and the grant search function for rr_arb_mux.
package rr_arb_mux_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    localparam int unsigned ARB_MODE_RR    = 0;
    localparam int unsigned ARB_MODE_FIXED = 1;

    // Upper bound on channel count accepted by next_grant.
    localparam int unsigned ARB_MAX_CH = 32;
    localparam int unsigned ARB_IDX_W  = 5;

    typedef struct packed {
        logic                 found;
        logic [ARB_IDX_W-1:0] idx;
    } grant_t;

    // Searches upward from the pointer with wrap at n (round-robin), or from 0 (fixed).
    function automatic grant_t next_grant(
        input logic [ARB_MAX_CH-1:0] valid,
        input logic [ARB_IDX_W-1:0]  pointer,
        input int unsigned           mode,
        input int unsigned           n
    );
        grant_t      g;
        int unsigned start;
        int unsigned c;
        g     = '0;
        start = (mode == ARB_MODE_FIXED) ? 0 : 32'(pointer);
        for (int unsigned i = 0; i < n; i++) begin
            c = start + i;
            if (c >= n) c = c - n;
            if (!g.found && valid[c[ARB_IDX_W-1:0]]) begin
                g.found = 1'b1;
                g.idx   = c[ARB_IDX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arb_mux_mux.sv
// Combinational P_WIDTH-to-1 channel multiplexer used by the rr_arb_mux data path.
module mux #(
    parameter int unsigned P_WIDTH = 4,
    parameter int unsigned P_DEPTH = 16
) (
    input  logic [P_WIDTH-1:0][P_DEPTH-1:0] I_INPUT,
    input  logic [$clog2(P_WIDTH)-1:0]      I_SELECT,
    output logic [P_DEPTH-1:0]              O_OUTPUT
);

    assign O_OUTPUT = I_INPUT[I_SELECT];

endmodule

// File: rtl/rr_arb_mux.sv
// Registered P_WIDTH-to-1 mux with round-robin / fixed-priority arbitration
// and burst locking on valid/ready channels.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned P_WIDTH = 4,
    parameter int unsigned P_DEPTH = 16,
    parameter int unsigned P_MODE  = 0
) (
    input  logic                            I_CLK,
    input  logic                            I_NRESET,
    input  logic [P_WIDTH-1:0]              I_VALID,
    input  logic [P_WIDTH-1:0][P_DEPTH-1:0] I_INPUT,
    input  logic [P_WIDTH-1:0]              I_LAST,
    output logic [P_WIDTH-1:0]              O_READY,
    output logic [P_DEPTH-1:0]              O_OUTPUT,
    output logic                            O_VALID,
    output logic                            O_LAST,
    output logic [$clog2(P_WIDTH)-1:0]      O_SELECT,
    input  logic                            I_READY
);

    localparam int unsigned SW = $clog2(P_WIDTH);

    arb_state_e         state_q;
    logic [SW-1:0]      lock_q;
    logic [SW-1:0]      ptr_q;
    logic [SW-1:0]      ptr_d;
    logic [P_DEPTH-1:0] out_q;
    logic               valid_q;
    logic               last_q;
    logic [SW-1:0]      sel_q;

    grant_t             gnt;
    logic [SW-1:0]      sel;
    logic [P_WIDTH-1:0] ready;
    logic               can_load;
    logic               xfer;
    logic [P_DEPTH-1:0] mux_out;

    assign can_load = !valid_q || I_READY;
    assign gnt      = next_grant(ARB_MAX_CH'(I_VALID), ARB_IDX_W'(ptr_q), P_MODE, P_WIDTH);
    assign sel      = (state_q == ARB_LOCKED) ? lock_q : SW'(gnt.idx);
    assign xfer     = |(I_VALID & ready);
    // Explicit wrap so non-power-of-2 widths never reach an unused index.
    assign ptr_d    = (sel == SW'(P_WIDTH - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        ready = '0;
        if (I_NRESET && can_load) begin
            if (state_q == ARB_LOCKED) begin
                ready[lock_q] = 1'b1;
            end else if (gnt.found) begin
                ready[sel] = 1'b1;
            end
        end
    end

    mux #(
        .P_WIDTH(P_WIDTH),
        .P_DEPTH(P_DEPTH)
    ) u_mux (
        .I_INPUT (I_INPUT),
        .I_SELECT(sel),
        .O_OUTPUT(mux_out)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= ARB_IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            if (xfer) begin
                out_q   <= mux_out;
                last_q  <= I_LAST[sel];
                sel_q   <= sel;
                valid_q <= 1'b1;
                case (state_q)
                    ARB_IDLE: begin
                        if (!I_LAST[sel]) begin
                            state_q <= ARB_LOCKED;
                            lock_q  <= sel;
                        end else if (P_MODE == ARB_MODE_RR) begin
                            ptr_q <= ptr_d;
                        end
                    end
                    ARB_LOCKED: begin
                        if (I_LAST[sel]) begin
                            state_q <= ARB_IDLE;
                            if (P_MODE == ARB_MODE_RR) ptr_q <= ptr_d;
                        end
                    end
                    default: state_q <= ARB_IDLE;
                endcase
            end else if (I_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign O_READY  = ready;
    assign O_OUTPUT = out_q;
    assign O_VALID  = valid_q;
    assign O_LAST   = last_q;
    assign O_SELECT = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin, burst lock, backpressure,
// async reset mid-burst, fixed priority and non-power-of-2 wrap.
module tb_rr_arb_mux;

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 4 channels, 16 bits, round-robin
    logic [3:0]       m_valid = '0;
    logic [3:0][15:0] m_data  = '0;
    logic [3:0]       m_last  = '0;
    logic [3:0]       m_ready;
    logic [15:0]      m_out;
    logic             m_ovalid;
    logic             m_olast;
    logic [1:0]       m_osel;
    logic             m_iready = 1'b1;

    // Fixed-priority DUT
    logic [3:0]       f_valid = '0;
    logic [3:0][15:0] f_data  = '0;
    logic [3:0]       f_last  = '0;
    logic [3:0]       f_ready;
    logic [15:0]      f_out;
    logic             f_ovalid;
    logic             f_olast;
    logic [1:0]       f_osel;

    // Three-channel DUT
    logic [2:0]       s_valid = '0;
    logic [2:0][1:0]  s_data  = '0;
    logic [2:0]       s_last  = '0;
    logic [2:0]       s_ready;
    logic [1:0]       s_out;
    logic             s_ovalid;
    logic             s_olast;
    logic [1:0]       s_osel;

    rr_arb_mux #(.P_WIDTH(4), .P_DEPTH(16), .P_MODE(0)) u_main (
        .I_CLK(clk), .I_NRESET(rst_n), .I_VALID(m_valid), .I_INPUT(m_data),
        .I_LAST(m_last), .O_READY(m_ready), .O_OUTPUT(m_out), .O_VALID(m_ovalid),
        .O_LAST(m_olast), .O_SELECT(m_osel), .I_READY(m_iready)
    );

    rr_arb_mux #(.P_WIDTH(4), .P_DEPTH(16), .P_MODE(1)) u_fixed (
        .I_CLK(clk), .I_NRESET(rst_n), .I_VALID(f_valid), .I_INPUT(f_data),
        .I_LAST(f_last), .O_READY(f_ready), .O_OUTPUT(f_out), .O_VALID(f_ovalid),
        .O_LAST(f_olast), .O_SELECT(f_osel), .I_READY(1'b1)
    );

    rr_arb_mux #(.P_WIDTH(3), .P_DEPTH(2), .P_MODE(0)) u_small (
        .I_CLK(clk), .I_NRESET(rst_n), .I_VALID(s_valid), .I_INPUT(s_data),
        .I_LAST(s_last), .O_READY(s_ready), .O_OUTPUT(s_out), .O_VALID(s_ovalid),
        .O_LAST(s_olast), .O_SELECT(s_osel), .I_READY(1'b1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [15:0] data, input logic last);
        beat_t b;
        b.sel  = sel;
        b.data = data;
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic pop_main(input string name);
        beat_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (m_ovalid !== 1'b1 || int'(m_osel) != e.sel || m_out !== e.data || m_olast !== e.last) begin
                failures++;
                $display("FAIL %s: got valid=%b sel=%0d data=%h last=%b, want valid=1 sel=%0d data=%h last=%b",
                         name, m_ovalid, m_osel, m_out, m_olast, e.sel, e.data, e.last);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_valid = 4'b1111;
        #2;
        checks++;
        if (m_ovalid !== 1'b0 || m_out !== 16'h0 || m_olast !== 1'b0 || m_osel !== 2'd0 || m_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset: got valid=%b data=%h last=%b sel=%0d ready=%b, want all zero",
                     m_ovalid, m_out, m_olast, m_osel, m_ready);
        end
        m_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_rr_single();
        m_iready = 1'b1;
        m_last   = 4'b1111;
        for (int i = 0; i < 4; i++) m_data[i] = 16'hA000 + 16'(i);
        m_valid = 4'b1111;
        #1;
        checks++;
        if (m_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rr_first_ready: got %b want 0001", m_ready);
        end
        for (int k = 0; k < 5; k++) push(k % 4, 16'hA000 + 16'(k % 4), 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            pop_main("rr_single");
        end
        m_valid = '0;
        step();
    endtask

    task automatic test_burst_lock();
        // pointer is 1 after the last grant to channel 0
        m_valid = 4'b1111;
        m_last  = 4'b1101;
        for (int k = 0; k < 3; k++) begin
            m_data[1] = 16'hB100 + 16'(k);
            if (k == 2) m_last = 4'b1111;
            #1;
            checks++;
            if (m_ready !== 4'b0010) begin
                failures++;
                $display("FAIL burst_ready beat %0d: got %b want 0010", k, m_ready);
            end
            push(1, 16'hB100 + 16'(k), k == 2);
            step();
            pop_main("burst_beat");
        end
        #1;
        checks++;
        if (m_ready !== 4'b0100) begin
            failures++;
            $display("FAIL burst_next_ready: got %b want 0100", m_ready);
        end
        push(2, m_data[2], 1'b1);
        step();
        pop_main("burst_next");
        m_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        // pointer is 3 here
        m_valid   = 4'b1000;
        m_last    = 4'b1111;
        m_data[3] = 16'h1234;
        push(3, 16'h1234, 1'b1);
        step();
        pop_main("bp_load");
        m_iready = 1'b0;
        m_valid  = 4'b1111;
        m_data[3] = 16'hDEAD;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (m_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready cycle %0d: got %b want 0000", k, m_ready);
            end
            push(3, 16'h1234, 1'b1);
            step();
            pop_main("bp_hold");
        end
        m_iready = 1'b1;
        #1;
        checks++;
        if (m_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 0001", m_ready);
        end
        push(0, m_data[0], 1'b1);
        step();
        pop_main("bp_release");
        m_valid = '0;
        step();
    endtask

    task automatic test_reset_burst();
        // pointer is 1: only channel 2 valid starts LOCKED(2)
        m_valid   = 4'b0100;
        m_last    = 4'b0000;
        m_data[2] = 16'hC200;
        push(2, 16'hC200, 1'b0);
        step();
        pop_main("rst_burst_beat0");
        m_data[2] = 16'hC201;
        push(2, 16'hC201, 1'b0);
        step();
        pop_main("rst_burst_beat1");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_ovalid !== 1'b0 || m_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rst_midburst: got valid=%b ready=%b want 0 0000", m_ovalid, m_ready);
        end
        m_valid = 4'b1111;
        m_last  = 4'b1111;
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (m_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_ready: got %b want 0001", m_ready);
        end
        push(0, m_data[0], 1'b1);
        step();
        pop_main("rst_first_grant");
        m_valid = '0;
        step();
    endtask

    task automatic test_fixed_priority();
        beat_t e;
        f_valid = 4'b1010;
        f_last  = 4'b1111;
        for (int i = 0; i < 4; i++) f_data[i] = 16'hF000 + 16'(i);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (f_ready !== 4'b0010) begin
                failures++;
                $display("FAIL fixed_ready cycle %0d: got %b want 0010", k, f_ready);
            end
            push(1, 16'hF001, 1'b1);
            step();
            e = sb.pop_front();
            checks++;
            if (f_ovalid !== 1'b1 || int'(f_osel) != e.sel || f_out !== e.data || f_olast !== e.last) begin
                failures++;
                $display("FAIL fixed_out cycle %0d: got valid=%b sel=%0d data=%h, want valid=1 sel=%0d data=%h",
                         k, f_ovalid, f_osel, f_out, e.sel, e.data);
            end
        end
        f_valid = '0;
        step();
    endtask

    task automatic test_np2_wrap();
        beat_t e;
        s_valid = 3'b111;
        s_last  = 3'b111;
        for (int i = 0; i < 3; i++) s_data[i] = 2'(i);
        for (int k = 0; k < 7; k++) push(k % 3, 16'(k % 3), 1'b1);
        for (int k = 0; k < 7; k++) begin
            step();
            e = sb.pop_front();
            checks++;
            if (s_ovalid !== 1'b1 || int'(s_osel) != e.sel || s_out !== e.data[1:0]) begin
                failures++;
                $display("FAIL np2_wrap cycle %0d: got valid=%b sel=%0d data=%0d, want valid=1 sel=%0d data=%0d",
                         k, s_ovalid, s_osel, s_out, e.sel, e.data[1:0]);
            end
        end
        s_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_burst_lock();
        test_backpressure();
        test_reset_burst();
        test_fixed_priority();
        test_np2_wrap();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
